// File: rtl/picorv32_soc_pkg.sv
// rtl/picorv32_soc_pkg.sv - shared SoC constants: UART register offsets, STATUS bits, FSM states
package picorv32_soc_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_CLKDIV = 4'h8;

  localparam int UART_STAT_FULL  = 0;
  localparam int UART_STAT_EMPTY = 1;
  localparam int UART_STAT_BUSY  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/picorv32_sync_fifo.sv
// rtl/picorv32_sync_fifo.sv - synchronous FIFO with registered full/empty and fall-through read
module picorv32_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/picorv32_uart_tx.sv
// rtl/picorv32_uart_tx.sv - memory-mapped 8N1 UART transmitter on the PicoRV32 native bus
module picorv32_uart_tx
  import picorv32_soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        sel,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq_empty
);

  uart_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] clkdiv_q, clkdiv_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        mem_ready_q, mem_ready_d;
  logic        done_q, done_d;

  logic [3:0]  reg_off;
  logic        txdata_wr, clkdiv_wr;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        busy;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  assign sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off = {mem_addr[3:2], 2'b00};
  assign busy    = (state_q != IDLE);

  // done_q marks a request already acknowledged so a held mem_valid is not acked twice.
  always_comb begin
    txdata_wr   = sel && mem_wstrb[0] && (reg_off == UART_TXDATA);
    clkdiv_wr   = sel && mem_wstrb[0] && (reg_off == UART_CLKDIV);
    mem_ready_d = sel && !done_q && !mem_ready_q && !(txdata_wr && fifo_full);
    done_d      = (mem_ready_q || done_q) && mem_valid;
    fifo_push   = mem_ready_q && txdata_wr;
    clkdiv_d    = (mem_ready_q && clkdiv_wr) ? mem_wdata[15:0] : clkdiv_q;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_ready_q && sel && (mem_wstrb == 4'b0000)) begin
      case (reg_off)
        UART_STATUS: begin
          mem_rdata[UART_STAT_FULL]  = fifo_full;
          mem_rdata[UART_STAT_EMPTY] = fifo_empty;
          mem_rdata[UART_STAT_BUSY]  = busy;
        end
        UART_CLKDIV: mem_rdata[15:0] = clkdiv_q;
        default:     mem_rdata = '0;
      endcase
    end
  end

  // The bit counter reloads from clkdiv_q only at bit boundaries, so a new divisor lands cleanly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = clkdiv_q;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = clkdiv_q;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = clkdiv_q;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = clkdiv_q;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      clkdiv_q    <= DEFAULT_DIV;
      mem_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      clkdiv_q    <= clkdiv_d;
      mem_ready_q <= mem_ready_d;
      done_q      <= done_d;
    end
  end

  picorv32_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .wdata_i(mem_wdata[7:0]),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign mem_ready = mem_ready_q;
  assign tx        = tx_q;
  assign irq_empty = fifo_empty && !busy;

endmodule

// File: tb/tb_picorv32_uart_tx.sv
// tb/tb_picorv32_uart_tx.sv - directed self-checking bench for picorv32_uart_tx
module tb_picorv32_uart_tx;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        sel, mem_ready, tx, irq_empty;
  logic [31:0] mem_rdata;

  int   errors = 0;
  int   checks = 0;
  int   cur_bit = -1;
  logic exp_bit [$];
  int   exp_len [$];
  logic [7:0] t2b [10];

  picorv32_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd867)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .sel      (sel),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .tx       (tx),
    .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata, output int lat);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready && lat < 3000);
    chk("bus ack", mem_ready, 1'b1);
    rdata = mem_rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    int l;
    bus(addr, data, 4'hF, r, l);
  endtask

  task automatic add_frame(input logic [7:0] b, input int len_a, input int split, input int len_b);
    for (int k = 0; k < 10; k++) begin
      exp_bit.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : b[k-1]));
      exp_len.push_back(k < split ? len_a : len_b);
    end
  endtask

  // Waits for a start bit, then checks tx every cycle against the queued bit/length list.
  task automatic check_stream(input string tag);
    int n, bad;
    n = 0;
    bad = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start"}, n < 500, 1'b1);
    for (int i = 0; i < exp_bit.size(); i++) begin
      for (int c = 0; c < exp_len[i]; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx !== exp_bit[i]) bad++;
        if (c == 0) cur_bit = i;
      end
    end
    cur_bit = -1;
    chk({tag, " bits"}, bad, 0);
    exp_bit.delete();
    exp_len.delete();
  endtask

  initial begin
    logic [31:0] d;
    int lat, maxlat, n, pulses, zeros, selseen;

    t2b = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h7E, 8'h81};

    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_ready", mem_ready, 1'b0);
    chk("reset mem_rdata", mem_rdata, 32'h0);
    chk("reset tx", tx, 1'b1);
    chk("reset irq_empty", irq_empty, 1'b1);
    reset = 1'b0;
    bus(BASE + 4, 0, 4'h0, d, lat);
    chk("reset status", d, 32'h2);
    chk("read latency", lat, 1);
    bus(BASE + 8, 0, 4'h0, d, lat);
    chk("reset clkdiv", d, 32'd867);

    // Single frame, 4 cycles per bit
    wr(BASE + 8, 3);
    bus(BASE + 8, 0, 4'h0, d, lat);
    chk("t1 clkdiv readback", d, 32'd3);
    add_frame(8'h41, 4, 10, 4);
    fork
      check_stream("t1 frame 0x41");
      wr(BASE, 32'h41);
    join
    @(negedge clk);
    chk("t1 idle after stop", tx, 1'b1);
    chk("t1 irq_empty after frame", irq_empty, 1'b1);

    // Divisor change in the middle of data bit 3
    wr(BASE + 8, 7);
    add_frame(8'hA5, 8, 5, 2);
    fork
      check_stream("t4 divisor switch");
      begin
        wr(BASE, 32'hA5);
        n = 0;
        while (cur_bit != 4 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        chk("t4 reached bit3", n < 1000, 1'b1);
        wr(BASE + 8, 1);
      end
    join

    // Fill FIFO plus shifter, then a stalled write; all ten frames contiguous
    wr(BASE + 8, 20);
    for (int i = 0; i < 10; i++) add_frame(t2b[i], 21, 10, 21);
    fork
      check_stream("t2 ten frames");
      begin
        maxlat = 0;
        for (int i = 0; i < 9; i++) begin
          bus(BASE, {24'h0, t2b[i]}, 4'hF, d, lat);
          if (lat > maxlat) maxlat = lat;
        end
        chk("t2 nine writes unstalled", maxlat, 1);
        bus(BASE + 4, 0, 4'h0, d, lat);
        chk("t3 status full busy", d, 32'h5);
        bus(BASE, {24'h0, t2b[9]}, 4'hF, d, lat);
        chk("t2 tenth write stalled", lat > 100, 1'b1);
      end
    join

    // CLKDIV=0: one cycle per bit, two frames back to back
    wr(BASE + 8, 0);
    add_frame(8'h5A, 1, 10, 1);
    add_frame(8'hC3, 1, 10, 1);
    fork
      check_stream("div0 frames");
      begin
        wr(BASE, 32'h5A);
        wr(BASE, 32'hC3);
      end
    join

    // Reset in the middle of DATA with bytes queued
    wr(BASE + 8, 3);
    for (int i = 0; i < 4; i++) wr(BASE, 32'h00 + i);
    bus(BASE + 4, 0, 4'h0, d, lat);
    chk("t5 status mid frame", d, 32'h4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5 tx after reset", tx, 1'b1);
    chk("t5 irq_empty after reset", irq_empty, 1'b1);
    bus(BASE + 4, 0, 4'h0, d, lat);
    chk("t5 status after reset", d, 32'h2);
    bus(BASE + 8, 0, 4'h0, d, lat);
    chk("t5 clkdiv after reset", d, 32'd867);
    bus(BASE, 32'h77, 4'b0010, d, lat);
    chk("wstrb0 low ack latency", lat, 1);
    bus(BASE + 12, 32'hFFFF_FFFF, 4'hF, d, lat);
    bus(BASE + 12, 0, 4'h0, d, lat);
    chk("reserved read", d, 32'h0);
    bus(BASE + 4, 0, 4'h0, d, lat);
    chk("status after ignored writes", d, 32'h2);
    zeros = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx === 1'b0) zeros++;
    end
    chk("t5 no frame after reset", zeros, 0);

    // Held request acked once; out-of-window request ignored
    mem_valid = 1'b1;
    mem_addr  = BASE + 8;
    mem_wstrb = 4'h0;
    pulses = 0;
    d = '0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        pulses++;
        d = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6 held pulses", pulses, 1);
    chk("t6 held rdata", d, 32'd867);
    chk("t6 rdata without ready", mem_rdata, 32'h0);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h10;
    mem_wdata = 32'h42;
    mem_wstrb = 4'hF;
    pulses = 0;
    selseen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
      if (sel) selseen++;
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    @(posedge clk); #1;
    chk("t6 outside sel", selseen, 0);
    chk("t6 outside pulses", pulses, 0);
    bus(BASE + 4, 0, 4'h0, d, lat);
    chk("t6 status unchanged", d, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
